hyperbus_trans_mux: RTL and testbench

- Multi-port front end for the HyperBus controller, system clock domain, between N AXI-side transfer sources and the single transfer/TX/RX/B channel set feeding the CDCs.
- Successor to the single-port attachment: generalised to NumPorts initiators with fair arbitration and in-order response routing.
- Tracks outstanding transfers and routes write data, read data and write responses to the originating port.

---
 rtl/hyperbus_pkg.sv | 15 +
 rtl/hyperbus_trans_mux_fifo.sv | 67 ++++++
 rtl/hyperbus_trans_mux.sv | 225 ++++++++++++++++++++++
 tb/tb_hyperbus_trans_mux.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus multi-port transfer front end.
//   MaxPortIdxW     : storage width of a port index inside the order FIFOs
//   order_entry_t   : one order-FIFO entry (index of the owning initiator port)
//   port_idx_width(): width needed to address NumPorts ports (never below 1)
package hyperbus_pkg;

    localparam int unsigned MaxPortIdxW = 8;

    typedef logic [MaxPortIdxW-1:0] order_entry_t;

    function automatic int unsigned port_idx_width(input int unsigned num_ports);
        return (num_ports <= 1) ? 1 : $clog2(num_ports);
    endfunction

endpackage

// File: rtl/hyperbus_trans_mux_fifo.sv
// Order FIFO holding the port index of each accepted transfer, oldest first.
//   clk_i, rst_i : system clock, asynchronous active-high reset
//   push_i/data_i: enqueue one entry (ignored when full unless popping too)
//   pop_i        : dequeue the head entry (ignored when empty)
//   data_o       : head entry, 0 when empty
//   full_o/empty_o
module hyperbus_trans_mux_fifo
    import hyperbus_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  order_entry_t data_i,
    input  logic         pop_i,
    output order_entry_t data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    order_entry_t    mem_q [Depth];
    order_entry_t    mem_d [Depth];
    logic [PtrW:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]   rd_ptr_q, rd_ptr_d;
    logic            pop_ok, push_ok;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[PtrW-1:0]];

    // A pop in the same cycle frees the slot a push on a full FIFO needs.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[PtrW-1:0]] = data_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/hyperbus_trans_mux.sv
// Multi-port front end of the HyperBus controller: round-robin merges the
// transfer requests of NumPorts initiators onto one transfer channel and routes
// TX data, RX data and B responses to/from the originating port in order.
//   in_trans_* : per-port transfer descriptor handshakes (merged onto trans_*)
//   in_tx_*    : per-port write data (merged onto tx_*, W-order head only)
//   in_rx_*    : read data, broadcast payload, per-port valid (R-order head)
//   in_b_*     : write response, broadcast error, per-port valid (B-order head)
//   outstanding_o / trans_active_o : accepted-but-uncompleted transfer count
module hyperbus_trans_mux
    import hyperbus_pkg::*;
#(
    parameter int unsigned NumPorts       = 2,
    parameter int unsigned NumChips       = 2,
    parameter int unsigned TransWidth     = 64,
    parameter int unsigned TxWidth        = 37,
    parameter int unsigned RxWidth        = 33,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,

    input  logic [NumPorts*TransWidth-1:0]     in_trans_i,
    input  logic [NumPorts*NumChips-1:0]       in_trans_cs_i,
    input  logic [NumPorts-1:0]                in_trans_write_i,
    input  logic [NumPorts-1:0]                in_trans_valid_i,
    output logic [NumPorts-1:0]                in_trans_ready_o,

    input  logic [NumPorts*TxWidth-1:0]        in_tx_i,
    input  logic [NumPorts-1:0]                in_tx_last_i,
    input  logic [NumPorts-1:0]                in_tx_valid_i,
    output logic [NumPorts-1:0]                in_tx_ready_o,

    output logic [RxWidth-1:0]                 in_rx_o,
    output logic                               in_rx_last_o,
    output logic [NumPorts-1:0]                in_rx_valid_o,
    input  logic [NumPorts-1:0]                in_rx_ready_i,

    output logic                               in_b_error_o,
    output logic [NumPorts-1:0]                in_b_valid_o,
    input  logic [NumPorts-1:0]                in_b_ready_i,

    output logic [TransWidth-1:0]              trans_o,
    output logic [NumChips-1:0]                trans_cs_o,
    output logic                               trans_write_o,
    output logic                               trans_valid_o,
    input  logic                               trans_ready_i,

    output logic [TxWidth-1:0]                 tx_o,
    output logic                               tx_last_o,
    output logic                               tx_valid_o,
    input  logic                               tx_ready_i,

    input  logic [RxWidth-1:0]                 rx_i,
    input  logic                               rx_last_i,
    input  logic                               rx_valid_i,
    output logic                               rx_ready_o,

    input  logic                               b_error_i,
    input  logic                               b_valid_i,
    output logic                               b_ready_o,

    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                               trans_active_o
);

    localparam int unsigned IdxW = port_idx_width(NumPorts);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic [CntW-1:0] count_q, count_d;

    logic [IdxW-1:0] grant_idx, cand;
    logic            grant_any, grant_write, block, trans_hs;

    order_entry_t    push_entry, w_head, b_head, r_head;
    logic            w_full, w_empty, b_full, b_empty, r_full, r_empty;
    logic            w_push, r_push, w_pop, b_pop, r_pop;
    logic            rx_route, b_route;

    // Round-robin search from the pointer; a stalled grant stays locked so the
    // offered descriptor cannot change until it is taken.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        if (lock_q) begin
            grant_idx = lock_idx_q;
            grant_any = in_trans_valid_i[lock_idx_q];
        end else begin
            for (int i = 0; i < int'(NumPorts); i++) begin
                cand = IdxW'((32'(rr_ptr_q) + 32'(i)) % NumPorts);
                if (!grant_any && in_trans_valid_i[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    assign grant_write = in_trans_write_i[grant_idx];

    // Writes occupy both a W and a B slot, reads an R slot.
    assign block = rst_i || (count_q == CntW'(MaxOutstanding)) ||
                   (grant_write ? (w_full || b_full) : r_full);

    assign trans_valid_o = grant_any && !block;
    assign trans_hs      = trans_valid_o && trans_ready_i;

    always_comb begin
        in_trans_ready_o = '0;
        trans_o          = '0;
        trans_cs_o       = '0;
        trans_write_o    = 1'b0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (trans_valid_o && grant_idx == IdxW'(p)) begin
                in_trans_ready_o[p] = trans_ready_i;
                trans_o             = in_trans_i[p*TransWidth +: TransWidth];
                trans_cs_o          = in_trans_cs_i[p*NumChips +: NumChips];
                trans_write_o       = in_trans_write_i[p];
            end
        end
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (trans_hs) begin
            lock_d   = 1'b0;
            rr_ptr_d = IdxW'((32'(grant_idx) + 32'd1) % NumPorts);
        end else if (trans_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = grant_idx;
        end
    end

    assign push_entry = order_entry_t'(grant_idx);
    assign w_push     = trans_hs && grant_write;
    assign r_push     = trans_hs && !grant_write;

    hyperbus_trans_mux_fifo #(.Depth(MaxOutstanding)) i_w_fifo (
        .clk_i, .rst_i, .push_i(w_push), .data_i(push_entry), .pop_i(w_pop),
        .data_o(w_head), .full_o(w_full), .empty_o(w_empty)
    );

    hyperbus_trans_mux_fifo #(.Depth(MaxOutstanding)) i_b_fifo (
        .clk_i, .rst_i, .push_i(w_push), .data_i(push_entry), .pop_i(b_pop),
        .data_o(b_head), .full_o(b_full), .empty_o(b_empty)
    );

    hyperbus_trans_mux_fifo #(.Depth(MaxOutstanding)) i_r_fifo (
        .clk_i, .rst_i, .push_i(r_push), .data_i(push_entry), .pop_i(r_pop),
        .data_o(r_head), .full_o(r_full), .empty_o(r_empty)
    );

    // Only the port at the W head can move write data.
    always_comb begin
        in_tx_ready_o = '0;
        tx_valid_o    = 1'b0;
        tx_last_o     = 1'b0;
        tx_o          = '0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (!w_empty && w_head == order_entry_t'(p)) begin
                in_tx_ready_o[p] = tx_ready_i;
                tx_valid_o       = in_tx_valid_i[p];
                tx_last_o        = in_tx_valid_i[p] && in_tx_last_i[p];
                tx_o             = in_tx_valid_i[p] ? in_tx_i[p*TxWidth +: TxWidth] : '0;
            end
        end
    end

    assign w_pop = tx_valid_o && tx_ready_i && tx_last_o;

    // With no owner queued, rx/b ready stays low so the beat waits upstream.
    always_comb begin
        in_rx_valid_o = '0;
        rx_ready_o    = 1'b0;
        in_b_valid_o  = '0;
        b_ready_o     = 1'b0;
        for (int p = 0; p < int'(NumPorts); p++) begin
            if (!r_empty && r_head == order_entry_t'(p)) begin
                in_rx_valid_o[p] = rx_valid_i;
                rx_ready_o       = in_rx_ready_i[p];
            end
            if (!b_empty && b_head == order_entry_t'(p)) begin
                in_b_valid_o[p] = b_valid_i;
                b_ready_o       = in_b_ready_i[p];
            end
        end
    end

    assign rx_route     = !r_empty && rx_valid_i;
    assign in_rx_o      = rx_route ? rx_i : '0;
    assign in_rx_last_o = rx_route && rx_last_i;
    assign r_pop        = rx_valid_i && rx_ready_o && rx_last_i;

    assign b_route      = !b_empty && b_valid_i;
    assign in_b_error_o = b_route && b_error_i;
    assign b_pop        = b_valid_i && b_ready_o;

    // Every completion matches an earlier accept, so the count cannot underflow.
    always_comb begin
        count_d = count_q + CntW'(trans_hs) - CntW'(b_pop) - CntW'(r_pop);
    end

    assign outstanding_o  = count_q;
    assign trans_active_o = (count_q != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            count_q    <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_hyperbus_trans_mux.sv
module tb_hyperbus_trans_mux;

    localparam int NP = 2;
    localparam int NC = 2;
    localparam int TW = 64;
    localparam int XW = 37;
    localparam int RW = 33;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic               clk, rst_i;
    logic [NP*TW-1:0]   in_trans_i;
    logic [NP*NC-1:0]   in_trans_cs_i;
    logic [NP-1:0]      in_trans_write_i, in_trans_valid_i, in_trans_ready_o;
    logic [NP*XW-1:0]   in_tx_i;
    logic [NP-1:0]      in_tx_last_i, in_tx_valid_i, in_tx_ready_o;
    logic [RW-1:0]      in_rx_o;
    logic               in_rx_last_o;
    logic [NP-1:0]      in_rx_valid_o, in_rx_ready_i;
    logic               in_b_error_o;
    logic [NP-1:0]      in_b_valid_o, in_b_ready_i;
    logic [TW-1:0]      trans_o;
    logic [NC-1:0]      trans_cs_o;
    logic               trans_write_o, trans_valid_o, trans_ready_i;
    logic [XW-1:0]      tx_o;
    logic               tx_last_o, tx_valid_o, tx_ready_i;
    logic [RW-1:0]      rx_i;
    logic               rx_last_i, rx_valid_i, rx_ready_o;
    logic               b_error_i, b_valid_i, b_ready_o;
    logic [CW-1:0]      outstanding_o;
    logic               trans_active_o;

    logic [TW-1:0] desc [NP];
    logic [XW-1:0] txd  [NP];
    assign in_trans_i    = {desc[1], desc[0]};
    assign in_tx_i       = {txd[1], txd[0]};
    assign in_trans_cs_i = {2'b10, 2'b01};

    hyperbus_trans_mux dut (
        .clk_i(clk), .rst_i(rst_i),
        .in_trans_i(in_trans_i), .in_trans_cs_i(in_trans_cs_i),
        .in_trans_write_i(in_trans_write_i), .in_trans_valid_i(in_trans_valid_i),
        .in_trans_ready_o(in_trans_ready_o),
        .in_tx_i(in_tx_i), .in_tx_last_i(in_tx_last_i), .in_tx_valid_i(in_tx_valid_i),
        .in_tx_ready_o(in_tx_ready_o),
        .in_rx_o(in_rx_o), .in_rx_last_o(in_rx_last_o), .in_rx_valid_o(in_rx_valid_o),
        .in_rx_ready_i(in_rx_ready_i),
        .in_b_error_o(in_b_error_o), .in_b_valid_o(in_b_valid_o), .in_b_ready_i(in_b_ready_i),
        .trans_o(trans_o), .trans_cs_o(trans_cs_o), .trans_write_o(trans_write_o),
        .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
        .tx_o(tx_o), .tx_last_o(tx_last_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .rx_i(rx_i), .rx_last_i(rx_last_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
        .b_error_i(b_error_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .outstanding_o(outstanding_o), .trans_active_o(trans_active_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish within time limit");
        $fatal(1);
    end

    typedef struct { int port; logic [TW-1:0] desc; logic [NC-1:0] cs; logic wr; } trans_exp_t;
    typedef struct { int port; logic [XW-1:0] data; logic last; } tx_exp_t;
    typedef struct { int port; logic [RW-1:0] data; logic last; } rx_exp_t;
    typedef struct { int port; logic err; } b_exp_t;

    trans_exp_t q_trans[$];
    tx_exp_t    q_tx[$];
    rx_exp_t    q_rx[$];
    b_exp_t     q_b[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: DUT handshake with no expected entry queued", name);
    endtask

    function automatic int idx_of(input logic [1:0] v);
        case (v)
            2'b01:   return 0;
            2'b10:   return 1;
            default: return -1;
        endcase
    endfunction

    // Scoreboard: every handshake the DUT completes is matched against the queue.
    trans_exp_t te;
    tx_exp_t    xe;
    rx_exp_t    re;
    b_exp_t     be;

    always @(negedge clk) begin
        if (!rst_i) begin
            if (trans_valid_o && trans_ready_i) begin
                if (q_trans.size() == 0) fail_now("trans_unexpected");
                else begin
                    te = q_trans.pop_front();
                    chk("trans_port",  64'(idx_of(in_trans_ready_o)), 64'(te.port));
                    chk("trans_desc",  trans_o, te.desc);
                    chk("trans_cs",    64'(trans_cs_o), 64'(te.cs));
                    chk("trans_write", 64'(trans_write_o), 64'(te.wr));
                end
            end
            if (tx_valid_o && tx_ready_i) begin
                if (q_tx.size() == 0) fail_now("tx_unexpected");
                else begin
                    xe = q_tx.pop_front();
                    chk("tx_port", 64'(idx_of(in_tx_ready_o)), 64'(xe.port));
                    chk("tx_data", 64'(tx_o), 64'(xe.data));
                    chk("tx_last", 64'(tx_last_o), 64'(xe.last));
                end
            end
            if (rx_valid_i && rx_ready_o) begin
                if (q_rx.size() == 0) fail_now("rx_unexpected");
                else begin
                    re = q_rx.pop_front();
                    chk("rx_port", 64'(idx_of(in_rx_valid_o)), 64'(re.port));
                    chk("rx_data", 64'(in_rx_o), 64'(re.data));
                    chk("rx_last", 64'(in_rx_last_o), 64'(re.last));
                end
            end
            if (b_valid_i && b_ready_o) begin
                if (q_b.size() == 0) fail_now("b_unexpected");
                else begin
                    be = q_b.pop_front();
                    chk("b_port",  64'(idx_of(in_b_valid_o)), 64'(be.port));
                    chk("b_error", 64'(in_b_error_o), 64'(be.err));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_trans(input int p);
        trans_exp_t e;
        e.port = p;
        e.desc = desc[p];
        e.cs   = (p == 0) ? 2'b01 : 2'b10;
        e.wr   = in_trans_write_i[p];
        q_trans.push_back(e);
    endtask

    task automatic rx_burst(input int port, input int tag);
        rx_exp_t e;
        for (int b = 0; b < 4; b++) begin
            e.port = port;
            e.data = {tag[0], 32'h1000_0000 + 32'(tag * 16 + b)};
            e.last = (b == 3);
            q_rx.push_back(e);
            rx_valid_i = 1'b1;
            rx_i       = e.data;
            rx_last_i  = e.last;
            tick();
        end
        rx_valid_i = 1'b0;
        rx_last_i  = 1'b0;
    endtask

    initial begin
        rx_exp_t re0;
        b_exp_t  b0;
        tx_exp_t x0;

        rst_i = 1'b1;
        desc[0] = '0; desc[1] = '0; txd[0] = '0; txd[1] = '0;
        in_trans_write_i = '0; in_trans_valid_i = 2'b11;
        in_tx_last_i = '0; in_tx_valid_i = '0;
        in_rx_ready_i = '0; in_b_ready_i = '0;
        trans_ready_i = 1'b1; tx_ready_i = 1'b0;
        rx_i = '0; rx_last_i = 1'b0; rx_valid_i = 1'b1;
        b_error_i = 1'b0; b_valid_i = 1'b1;

        // Reset state, with requests present that must be masked.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outstanding",  64'(outstanding_o), 64'd0);
        chk("rst_active",       64'(trans_active_o), 64'd0);
        chk("rst_trans_valid",  64'(trans_valid_o), 64'd0);
        chk("rst_in_ready",     64'(in_trans_ready_o), 64'd0);
        chk("rst_rx_ready",     64'(rx_ready_o), 64'd0);
        chk("rst_b_ready",      64'(b_ready_o), 64'd0);
        chk("rst_trans_data",   trans_o, 64'd0);
        in_trans_valid_i = '0; rx_valid_i = 1'b0; b_valid_i = 1'b0;
        rst_i = 1'b0;
        tick();

        // Both ports read continuously: grants alternate 0,1,0,1 until full.
        desc[0] = 64'hA000_0000_0000_0001;
        desc[1] = 64'hB000_0000_0000_0001;
        in_rx_ready_i = 2'b11;
        in_b_ready_i  = 2'b11;
        for (int i = 0; i < 4; i++) exp_trans(i % 2);
        in_trans_valid_i = 2'b11;
        repeat (4) tick();
        in_trans_valid_i = '0;
        #1;
        chk("full_count", 64'(outstanding_o), 64'd4);
        in_trans_valid_i = 2'b01;
        #1;
        chk("full_trans_valid", 64'(trans_valid_o), 64'd0);
        chk("full_in_ready",    64'(in_trans_ready_o), 64'd0);
        tick();
        in_trans_valid_i = '0;

        rx_burst(0, 0);
        #1;
        chk("count_after_rx_last", 64'(outstanding_o), 64'd3);
        in_trans_valid_i = 2'b10;
        exp_trans(1);
        #1;
        chk("reaccept_ready", 64'(in_trans_ready_o), 64'b10);
        tick();
        in_trans_valid_i = '0;
        #1;
        chk("count_refilled", 64'(outstanding_o), 64'd4);
        rx_burst(1, 1);
        rx_burst(0, 2);
        rx_burst(1, 3);
        rx_burst(1, 4);
        #1;
        chk("count_drained", 64'(outstanding_o), 64'd0);

        // Grant lock: port 1 write stalled while port 0 (pointer favoured) asks.
        trans_ready_i = 1'b0;
        desc[1] = 64'hB000_0000_0000_0002;
        desc[0] = 64'hA000_0000_0000_0002;
        in_trans_write_i = 2'b11;
        in_trans_valid_i = 2'b10;
        exp_trans(1);
        tick();
        in_trans_valid_i = 2'b11;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("lock_desc",  trans_o, 64'hB000_0000_0000_0002);
            chk("lock_valid", 64'(trans_valid_o), 64'd1);
            tick();
        end
        exp_trans(0);
        trans_ready_i = 1'b1;
        tick();
        in_trans_valid_i = 2'b01;
        tick();
        in_trans_valid_i = '0;

        // TX ordering: port 0 data waits behind port 1's burst.
        tx_ready_i = 1'b1;
        txd[0] = 37'h0_0C0D_E000;
        in_tx_valid_i = 2'b01;
        in_tx_last_i  = 2'b01;
        #1;
        chk("tx_p0_blocked_ready", 64'(in_tx_ready_o[0]), 64'd0);
        chk("tx_p0_blocked_valid", 64'(tx_valid_o), 64'd0);
        tick();
        chk("tx_p0_still_blocked", 64'(in_tx_ready_o[0]), 64'd0);
        x0.port = 1; x0.data = 37'h1_1111_0001; x0.last = 1'b0; q_tx.push_back(x0);
        txd[1] = x0.data;
        in_tx_valid_i = 2'b11;
        in_tx_last_i  = 2'b01;
        tick();
        x0.port = 1; x0.data = 37'h1_1111_0002; x0.last = 1'b1; q_tx.push_back(x0);
        txd[1] = x0.data;
        in_tx_last_i = 2'b11;
        tick();
        in_tx_valid_i = 2'b01;
        in_tx_last_i  = 2'b01;
        x0.port = 0; x0.data = 37'h0_0C0D_E000; x0.last = 1'b1; q_tx.push_back(x0);
        tick();
        in_tx_valid_i = '0;
        in_tx_last_i  = '0;

        b0.port = 1; b0.err = 1'b0; q_b.push_back(b0);
        b_valid_i = 1'b1; b_error_i = 1'b0;
        tick();
        b0.port = 0; b0.err = 1'b1; q_b.push_back(b0);
        b_error_i = 1'b1;
        tick();
        b_valid_i = 1'b0; b_error_i = 1'b0;
        #1;
        chk("count_after_b", 64'(outstanding_o), 64'd0);

        // Spurious B with nothing outstanding stalls instead of dropping.
        b_valid_i = 1'b1;
        #1;
        chk("b_empty_ready", 64'(b_ready_o), 64'd0);
        chk("b_empty_valid", 64'(in_b_valid_o), 64'd0);
        repeat (3) tick();
        chk("b_empty_ready_held", 64'(b_ready_o), 64'd0);
        chk("b_empty_count",      64'(outstanding_o), 64'd0);
        b_valid_i = 1'b0;

        // Write from port 0, read from port 1, then accept + two completions.
        desc[0] = 64'hA000_0000_0000_0003;
        in_trans_write_i = 2'b01;
        in_trans_valid_i = 2'b01;
        exp_trans(0);
        tick();
        desc[1] = 64'hB000_0000_0000_0003;
        in_trans_valid_i = 2'b10;
        exp_trans(1);
        tick();
        in_trans_valid_i = '0;
        x0.port = 0; x0.data = 37'h0_0000_0ABC; x0.last = 1'b1; q_tx.push_back(x0);
        txd[0] = x0.data;
        in_tx_valid_i = 2'b01; in_tx_last_i = 2'b01;
        tick();
        in_tx_valid_i = '0; in_tx_last_i = '0;

        desc[0] = 64'hA000_0000_0000_0004;
        in_trans_write_i = 2'b00;
        in_trans_valid_i = 2'b01;
        exp_trans(0);
        b0.port = 0; b0.err = 1'b0; q_b.push_back(b0);
        b_valid_i = 1'b1; b_error_i = 1'b0;
        re0.port = 1; re0.data = 33'h0_5555_AAAA; re0.last = 1'b1; q_rx.push_back(re0);
        rx_valid_i = 1'b1; rx_i = re0.data; rx_last_i = 1'b1;
        #1;
        chk("combo_count_before", 64'(outstanding_o), 64'd2);
        tick();
        in_trans_valid_i = '0; b_valid_i = 1'b0; rx_valid_i = 1'b0; rx_last_i = 1'b0;
        #1;
        chk("combo_count_after", 64'(outstanding_o), 64'd1);

        // Three reads outstanding, reset in the middle of a burst.
        desc[1] = 64'hB000_0000_0000_0005;
        in_trans_valid_i = 2'b10;
        exp_trans(1);
        tick();
        desc[0] = 64'hA000_0000_0000_0006;
        in_trans_valid_i = 2'b01;
        exp_trans(0);
        tick();
        in_trans_valid_i = '0;
        #1;
        chk("pre_reset_count", 64'(outstanding_o), 64'd3);
        for (int b = 0; b < 2; b++) begin
            re0.port = 0; re0.data = 33'(32'h2000_0000 + 32'(b)); re0.last = 1'b0;
            q_rx.push_back(re0);
            rx_valid_i = 1'b1; rx_i = re0.data; rx_last_i = 1'b0;
            tick();
        end
        rst_i = 1'b1;
        in_trans_valid_i = 2'b11;
        #1;
        chk("midrst_count",       64'(outstanding_o), 64'd0);
        chk("midrst_trans_valid", 64'(trans_valid_o), 64'd0);
        chk("midrst_rx_valid",    64'(in_rx_valid_o), 64'd0);
        chk("midrst_rx_ready",    64'(rx_ready_o), 64'd0);
        tick();
        rst_i = 1'b0;
        rx_valid_i = 1'b0;
        in_trans_valid_i = '0;
        #1;
        chk("postrst_count",  64'(outstanding_o), 64'd0);
        chk("postrst_active", 64'(trans_active_o), 64'd0);
        desc[1] = 64'hB000_0000_0000_0007;
        in_trans_valid_i = 2'b10;
        exp_trans(1);
        #1;
        chk("postrst_grant_p1", 64'(in_trans_ready_o), 64'b10);
        tick();
        in_trans_valid_i = '0;
        #1;
        chk("postrst_count_one", 64'(outstanding_o), 64'd1);

        repeat (2) tick();
        chk("trans_queue_drained", 64'(q_trans.size()), 64'd0);
        chk("tx_queue_drained",    64'(q_tx.size()), 64'd0);
        chk("rx_queue_drained",    64'(q_rx.size()), 64'd0);
        chk("b_queue_drained",     64'(q_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
